// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver.
// Synchronizes and deglitches the PS/2 pins and assembles 11-bit frames.
// Each good scan-code byte is emitted with a one-cycle strobe.
// Parity, stop-bit and inter-edge timeout faults produce error pulses;
// a faulty frame never updates received_data.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic             clk_sync_p0, clk_sync_p1;
    logic             dat_sync_p0, dat_sync_p1;
    logic [FLT_W-1:0] filt_cnt;
    logic             clk_filt, clk_prev;
    logic             fall, bit_in;

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       data_d;
    logic             en_d, perr_d, ferr_d;

    // Two-flop synchronizers for both pins; idle bus level is high.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            clk_sync_p0 <= 1'b1;
            clk_sync_p1 <= 1'b1;
            dat_sync_p0 <= 1'b1;
            dat_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0 <= PS2_CLK;
            clk_sync_p1 <= clk_sync_p0;
            dat_sync_p0 <= PS2_DAT;
            dat_sync_p1 <= dat_sync_p0;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            filt_cnt <= '0;
            clk_filt <= 1'b1;
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_filt;
            if (clk_sync_p1 != clk_filt) begin
                if (filt_cnt == FLT_LAST) begin
                    clk_filt <= clk_sync_p1;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FLT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall   = clk_prev & ~clk_filt;
    assign bit_in = dat_sync_p1;
    assign busy   = (state_q != IDLE);

    // Next-state, shift/timeout bookkeeping and next output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        data_d    = received_data;
        en_d      = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        // A fall always restarts the inter-edge timer, so it beats a timeout.
        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            ferr_d  = 1'b1;
            state_d = IDLE;
            shift_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = bit_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!bit_in) begin
                        ferr_d = 1'b1;
                    end else if (!parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        data_d = shift_q;
                        en_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame assembly registers and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            shift_q          <= '0;
            bit_cnt_q        <= '0;
            par_q            <= 1'b0;
            tmo_q            <= '0;
            received_data    <= '0;
            received_data_en <= 1'b0;
            parity_error     <= 1'b0;
            frame_error      <= 1'b0;
        end else begin
            shift_q          <= shift_d;
            bit_cnt_q        <= bit_cnt_d;
            par_q            <= par_d;
            tmo_q            <= tmo_d;
            received_data    <= data_d;
            received_data_en <= en_d;
            parity_error     <= perr_d;
            frame_error      <= ferr_d;
        end
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Receive-only PS/2 device-to-host deserializer, sitting directly upstream of the keyboard input controller.
- Synchronizes and deglitches PS2_CLK/PS2_DAT, assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop) and emits each valid scan-code byte with a one-cycle strobe.
- Flags parity, stop-bit and timeout faults instead of passing bad bytes downstream.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 100000: maximum CLOCK_50 cycles allowed between falling edges inside a frame (2 ms at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset_n  input  1  synchronous active-low reset
- PS2_CLK  input  1  PS/2 clock pin (receive-only; pin not driven by this block)
- PS2_DAT  input  1  PS/2 data pin
- received_data  output  8  last good byte; holds until the next good frame
- received_data_en  output  1  one-cycle strobe, received_data valid on the same cycle
- parity_error  output  1  one-cycle pulse: frame with an even count of ones over data+parity
- frame_error  output  1  one-cycle pulse: stop bit 0, or inter-edge timeout
- busy  output  1  high while state != IDLE

Behaviour:
- All logic on posedge CLOCK_50. Reset is applied when reset_n=0 at a clock edge.
- Reset values:
  - received_data=0x00; received_data_en=0; parity_error=0; frame_error=0; busy=0.
  - state=IDLE; shift register=0; bit counter=0; timeout counter=0.
  - Synchronizer flops=1; filtered clock=1; previous filtered clock=1.
- Synchronization: both pins pass through 2-flop synchronizers.
- Clock filter: a counter tracks how long the synchronized clock has differed from the filtered clock. The filtered clock takes the new level once the difference has held FILTER_LEN consecutive cycles. Any agreeing sample clears the counter. Pulses shorter than FILTER_LEN cycles are ignored.
- fall = prev_filtered & ~filtered, a single cycle. On a fall cycle, the sampled bit is the synchronized PS2_DAT.
- FSM, advancing only on fall cycles except for timeout:
  - IDLE: bit=0 -> DATA with bit counter=0; bit=1 -> stay in IDLE (no error).
  - DATA: shift the bit into shift[7] with a right shift, so the first received bit ends up in bit 0. Increment the counter; after the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: always -> IDLE. Then, in priority order:
    - stop bit 0: frame_error pulse.
    - else parity bad: parity_error pulse.
    - else: received_data<=shift, received_data_en pulse.
  - At most one of the three strobes fires per frame.
- Output timing: outputs are registered and are high the cycle after the STOP fall cycle, for exactly one cycle. Total latency from the pin falling edge is about 2+FILTER_LEN+1 cycles.
- Timeout:
  - The counter clears on every fall and is held at 0 in IDLE.
  - In any other state, if it reaches TIMEOUT_CYCLES-1 without a fall: frame_error pulse, state -> IDLE, partial byte discarded.
  - If a fall and the timeout coincide, the fall wins.
- Reset mid-frame: the frame is abandoned with no strobe. The next frame must begin with a fresh start bit.
- Frames arriving back to back with no idle gap are accepted. IDLE accepts a start bit on the first fall after STOP.

Test Plan (bench uses FILTER_LEN=4, TIMEOUT_CYCLES=2000, PS/2 bit period 400 CLOCK_50 cycles):
- Send 0x1C with parity 0 and stop 1 -> exactly one received_data_en cycle with received_data=0x1C. No error pulse; busy returns to 0.
- Send 0xF0 (parity 1) then 0x1C back to back -> two strobes, data 0xF0 then 0x1C; received_data holds 0x1C afterwards.
- Send 0x45 with parity 1 (wrong) -> one parity_error pulse, no strobe, received_data unchanged from the prior value.
- Send 0x5A with correct parity 1 and stop bit 0 -> one frame_error pulse, no strobe, no parity_error.
- Send a start bit plus 4 data bits, then hold PS2_CLK high for 3000 cycles -> frame_error pulse after 2000 idle cycles and busy=0. A following 0x5A frame (parity 1) yields a strobe with 0x5A.
- Glitches and reset:
  - 2-cycle low pulse on PS2_CLK while idle -> no state change, busy stays 0.
  - reset_n=0 for one cycle after bit 5 of a frame -> no strobe or error, all outputs 0. A next clean frame 0x16 is received correctly.
